// File: rtl/red_pitaya_fads_sort_ctrl_if.sv
// System bus bundle for the FADS sort sequencer.
// The master drives address/strobes; the slave returns data and ack.
interface red_pitaya_fads_sort_ctrl_if;
  logic [31:0] sys_addr;
  logic [31:0] sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen;
  logic        sys_ren;
  logic [31:0] sys_rdata;
  logic        sys_err;
  logic        sys_ack;

  modport master (
    output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    input  sys_rdata, sys_err, sys_ack
  );

  modport slave (
    input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
    output sys_rdata, sys_err, sys_ack
  );
endinterface

// File: rtl/red_pitaya_fads_sort_ctrl.sv
// FADS sort sequencer: width-qualifies droplets, waits the flight
// delay, fires a timed ASG trigger, then holds off for a dead time.
module red_pitaya_fads_sort_ctrl #(
  parameter int CW = 32
) (
  input  logic adc_clk_i,
  input  logic adc_rst_i,
  input  logic det_i,
  output logic asg_trig_o,
  output logic busy_o,
  red_pitaya_fads_sort_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEAS = 3'd1,
    S_WAIT = 3'd2,
    S_FIRE = 3'd3,
    S_HOLD = 3'd4
  } state_t;

  state_t state, state_n;
  logic [19:0] cnt, cnt_n;
  logic det_q, det_p;
  logic skip, skip_n;
  logic inc_drop, inc_sort, inc_miss;

  logic        ctrl_en;
  logic [15:0] min_w, max_w, pulse;
  logic [19:0] delay, hold;
  logic [CW-1:0] n_drop, n_sort, n_miss;
  logic [31:0] rd_mux;

  logic [19:0] addr;
  logic wr, clr;
  logic unused_ok;

  assign addr = bus.sys_addr[19:0];
  assign wr   = bus.sys_wen;
  assign clr  = wr && (addr == 20'h0) && bus.sys_wdata[1];
  assign unused_ok = ^{bus.sys_sel, bus.sys_addr[31:20]};
  assign bus.sys_err = 1'b0;

  // A detection that rose while busy is skipped until it goes low.
  assign inc_miss = det_q && !det_p &&
    (state == S_WAIT || state == S_FIRE || state == S_HOLD);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    inc_drop = 1'b0;
    inc_sort = 1'b0;
    skip_n   = skip;
    if (!det_q)
      skip_n = 1'b0;
    else if (inc_miss)
      skip_n = 1'b1;
    if (!ctrl_en) begin
      state_n = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (det_q && !skip) begin
          state_n = S_MEAS;
          cnt_n   = 20'd1;
        end
        S_MEAS: if (det_q) begin
          if (cnt[15:0] != 16'hFFFF)
            cnt_n = cnt + 20'd1;
        end else begin
          inc_drop = 1'b1;
          if (cnt[15:0] >= min_w && cnt[15:0] <= max_w) begin
            state_n = S_WAIT;
            cnt_n   = delay;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_WAIT: if (cnt == 20'd0) begin
          state_n  = S_FIRE;
          cnt_n    = {4'h0, (pulse == 16'd0) ? 16'd1 : pulse};
          inc_sort = 1'b1;
        end else begin
          cnt_n = cnt - 20'd1;
        end
        S_FIRE: if (cnt <= 20'd1) begin
          state_n = S_HOLD;
          cnt_n   = hold;
        end else begin
          cnt_n = cnt - 20'd1;
        end
        S_HOLD: if (cnt == 20'd0)
          state_n = S_IDLE;
        else
          cnt_n = cnt - 20'd1;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state      <= S_IDLE;
      cnt        <= '0;
      det_q      <= 1'b0;
      det_p      <= 1'b0;
      skip       <= 1'b0;
      asg_trig_o <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      det_q      <= det_i;
      det_p      <= det_q;
      skip       <= skip_n;
      asg_trig_o <= (state_n == S_FIRE);
      busy_o     <= (state_n != S_IDLE);
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      n_drop <= '0;
      n_sort <= '0;
      n_miss <= '0;
    end else begin
      n_drop <= clr ? '0 : n_drop + CW'(inc_drop);
      n_sort <= clr ? '0 : n_sort + CW'(inc_sort);
      n_miss <= clr ? '0 : n_miss + CW'(inc_miss);
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      ctrl_en <= 1'b0;
      min_w   <= 16'd1;
      max_w   <= 16'hFFFF;
      delay   <= '0;
      pulse   <= 16'd1;
      hold    <= '0;
    end else if (wr) begin
      unique case (addr)
        20'h00: ctrl_en <= bus.sys_wdata[0];
        20'h04: min_w   <= bus.sys_wdata[15:0];
        20'h08: max_w   <= bus.sys_wdata[15:0];
        20'h0C: delay   <= bus.sys_wdata[19:0];
        20'h10: pulse   <= bus.sys_wdata[15:0];
        20'h14: hold    <= bus.sys_wdata[19:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      20'h00: rd_mux = {31'h0, ctrl_en};
      20'h04: rd_mux = {16'h0, min_w};
      20'h08: rd_mux = {16'h0, max_w};
      20'h0C: rd_mux = {12'h0, delay};
      20'h10: rd_mux = {16'h0, pulse};
      20'h14: rd_mux = {12'h0, hold};
      20'h18: rd_mux = 32'(n_drop);
      20'h1C: rd_mux = 32'(n_sort);
      20'h20: rd_mux = 32'(n_miss);
      20'h24: rd_mux = {28'h0, asg_trig_o, 3'(state)};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      bus.sys_ack   <= 1'b0;
      bus.sys_rdata <= '0;
    end else begin
      bus.sys_ack   <= bus.sys_wen | bus.sys_ren;
      bus.sys_rdata <= bus.sys_ren ? rd_mux : 32'h0;
    end
  end

endmodule

// File: tb/tb_red_pitaya_fads_sort_ctrl.sv
// Directed bench for the FADS sort sequencer: cycle vector tables
// plus hand sequences for miss, abort, reset and bus behaviour.
module tb_red_pitaya_fads_sort_ctrl;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_MINW  = 32'h04;
  localparam logic [31:0] A_MAXW  = 32'h08;
  localparam logic [31:0] A_DELAY = 32'h0C;
  localparam logic [31:0] A_PULSE = 32'h10;
  localparam logic [31:0] A_HOLD  = 32'h14;
  localparam logic [31:0] A_NDROP = 32'h18;
  localparam logic [31:0] A_NSORT = 32'h1C;
  localparam logic [31:0] A_NMISS = 32'h20;
  localparam logic [31:0] A_STAT  = 32'h24;

  typedef struct packed {
    logic [1:0] grp;
    logic       det;
    logic       trig;
    logic       busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic det = 1'b0;
  logic trig, busy;
  int nerr = 0;
  int nchk = 0;
  vec_t vq[$];

  red_pitaya_fads_sort_ctrl_if bus();

  red_pitaya_fads_sort_ctrl #(.CW(32)) dut (
    .adc_clk_i  (clk),
    .adc_rst_i  (rst),
    .det_i      (det),
    .asg_trig_o (trig),
    .busy_o     (busy),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sys_addr  = a;
    bus.sys_wdata = d;
    bus.sys_wen   = 1'b1;
    tick();
    bus.sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input string name, input logic [31:0] a,
                        input logic [31:0] exp);
    @(negedge clk);
    bus.sys_addr = a;
    bus.sys_ren  = 1'b1;
    tick();
    bus.sys_ren = 1'b0;
    chk({name, "_ack"}, {31'h0, bus.sys_ack}, 32'h1);
    chk(name, bus.sys_rdata, exp);
  endtask

  task automatic run_grp(input logic [1:0] g, input string name);
    int i;
    i = 0;
    foreach (vq[k]) begin
      if (vq[k].grp == g) begin
        @(negedge clk);
        det = vq[k].det;
        tick();
        chk($sformatf("%s_trig%0d", name, i), {31'h0, trig},
            {31'h0, vq[k].trig});
        chk($sformatf("%s_busy%0d", name, i), {31'h0, busy},
            {31'h0, vq[k].busy});
        i++;
      end
    end
    det = 1'b0;
  endtask

  // Droplet of 6 cycles; returns once the trigger is seen high.
  task automatic fire_up(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      det = (i < 6);
      tick();
      seen = trig;
    end
    det = 1'b0;
    chk({name, "_fire_seen"}, {31'h0, seen}, 32'h1);
  endtask

  function automatic void add(input logic [1:0] g, input logic d,
                              input logic t, input logic b);
    vec_t v;
    v.grp  = g;
    v.det  = d;
    v.trig = t;
    v.busy = b;
    vq.push_back(v);
  endfunction

  initial begin
    int ntrig;

    // accept: width 6, DELAY 5, PULSE 3, HOLD 2; t0 at vector 6
    for (int i = 0; i < 22; i++)
      add(2'd0, i < 6, i >= 13 && i <= 15, i >= 1 && i <= 18);
    // reject: widths 3 and 11 against the 4..10 window
    for (int i = 0; i < 24; i++)
      add(2'd1, (i < 3) || (i >= 8 && i < 19), 1'b0,
          (i >= 1 && i <= 3) || (i >= 9 && i <= 19));
    // PULSE=0, DELAY=0, HOLD=0: single-cycle trigger at t0+2
    for (int i = 0; i < 12; i++)
      add(2'd2, i < 5, i == 7, i >= 1 && i <= 8);

    bus.sys_addr  = '0;
    bus.sys_wdata = '0;
    bus.sys_sel   = 4'hF;
    bus.sys_wen   = 1'b0;
    bus.sys_ren   = 1'b0;

    #1;
    chk("rst_trig", {31'h0, trig}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ack", {31'h0, bus.sys_ack}, 32'h0);
    chk("rst_err", {31'h0, bus.sys_err}, 32'h0);
    chk("rst_rdata", bus.sys_rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    bus_rd("rst_ctrl", A_CTRL, 32'h0);
    bus_rd("rst_minw", A_MINW, 32'h1);
    bus_rd("rst_maxw", A_MAXW, 32'hFFFF);
    bus_rd("rst_pulse", A_PULSE, 32'h1);
    bus_rd("rst_hold", A_HOLD, 32'h0);
    bus_rd("unmapped", 32'h28, 32'h0);

    bus_wr(A_MINW, 32'd4);
    bus_wr(A_MAXW, 32'd10);
    bus_wr(A_DELAY, 32'd5);
    bus_wr(A_PULSE, 32'd3);
    bus_wr(A_HOLD, 32'd2);
    bus_wr(A_CTRL, 32'h1);
    bus_rd("ctrl_rd", A_CTRL, 32'h1);

    run_grp(2'd0, "accept");
    bus_rd("acc_ndrop", A_NDROP, 32'd1);
    bus_rd("acc_nsort", A_NSORT, 32'd1);

    bus_wr(A_CTRL, 32'h3);
    run_grp(2'd1, "reject");
    bus_rd("rej_ndrop", A_NDROP, 32'd2);
    bus_rd("rej_nsort", A_NSORT, 32'd0);

    // miss: second droplet rises 5 cycles after the first falls
    bus_wr(A_DELAY, 32'd20);
    bus_wr(A_CTRL, 32'h3);
    ntrig = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      det = (i < 6) || (i >= 11 && i < 14);
      tick();
      if (trig) ntrig++;
    end
    det = 1'b0;
    chk("miss_trig_len", ntrig, 32'd3);
    chk("miss_idle", {31'h0, busy}, 32'h0);
    bus_rd("miss_nmiss", A_NMISS, 32'd1);
    bus_rd("miss_ndrop", A_NDROP, 32'd1);
    bus_rd("miss_nsort", A_NSORT, 32'd1);

    // abort: EN cleared while firing a long pulse
    bus_wr(A_DELAY, 32'd0);
    bus_wr(A_PULSE, 32'd10);
    bus_wr(A_HOLD, 32'd0);
    bus_wr(A_CTRL, 32'h3);
    fire_up("abort");
    bus_wr(A_CTRL, 32'h0);
    chk("abort_still_fire", {31'h0, trig}, 32'h1);
    tick();
    chk("abort_trig", {31'h0, trig}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    bus_rd("abort_status", A_STAT, 32'h0);
    bus_rd("abort_ndrop", A_NDROP, 32'd1);
    bus_rd("abort_nsort", A_NSORT, 32'd1);
    bus_rd("abort_nmiss", A_NMISS, 32'd0);

    bus_wr(A_NDROP, 32'd55);
    bus_rd("ro_ignored", A_NDROP, 32'd1);
    bus_wr(A_CTRL, 32'h3);
    bus_rd("clr_ndrop", A_NDROP, 32'd0);
    bus_rd("clr_nsort", A_NSORT, 32'd0);
    bus_rd("clr_ctrl", A_CTRL, 32'h1);

    bus_wr(A_PULSE, 32'd0);
    run_grp(2'd2, "edge");
    bus_rd("edge_nsort", A_NSORT, 32'd1);

    // asynchronous reset in the middle of a trigger
    bus_wr(A_PULSE, 32'd10);
    fire_up("reset");
    bus_rd("fire_status", A_STAT, 32'hB);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_trig", {31'h0, trig}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_rd("arst_maxw", A_MAXW, 32'hFFFF);
    tick();
    chk("ack_one_cycle", {31'h0, bus.sys_ack}, 32'h0);
    bus_rd("arst_ctrl", A_CTRL, 32'h0);
    bus_rd("arst_nsort", A_NSORT, 32'h0);
    bus_rd("arst_status", A_STAT, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/red_pitaya_fads_sort_ctrl.md
# red_pitaya_fads_sort_ctrl

Sort sequencer for the FADS path. It takes the registered in-window detection flag from the fluorescence threshold comparator and qualifies each droplet by pulse width. For accepted droplets it waits a programmable flight delay, then issues a timed trigger to the ASG/high-voltage chain, followed by a dead time. It sits between the comparator and the ASG trigger input, is configured over the system bus, and exposes droplet, sort and miss counters.

## Interface
Parameters:
- `CW`, 32: width of the statistics counters.

Ports:
- `adc_clk_i` in 1: ADC clock; the only clock.
- `adc_rst_i` in 1: reset, asynchronous, active-high.
- `det_i` in 1: detection flag from the comparator, synchronous to `adc_clk_i`.
- `asg_trig_o` out 1: sort trigger to the ASG; high for the programmed pulse length.
- `busy_o` out 1: high in any state other than IDLE.
- `sys_addr` in 32: bus address; bits [19:0] are decoded.
- `sys_wdata` in 32: bus write data.
- `sys_sel` in 4: byte select; ignored, writes are full-word.
- `sys_wen` in 1: write strobe.
- `sys_ren` in 1: read strobe.
- `sys_rdata` out 32: read data.
- `sys_err` out 1: always 0.
- `sys_ack` out 1: acknowledge.

## Operation
Register map (offset, reset value):
- 0x00 CTRL (0x0):
  - bit0 EN.
  - bit1 CLR is write-1 and self-clearing; it zeroes all three counters on the next edge. It reads as 0.
- 0x04 MIN_W, 16 bit (1): minimum accepted width in cycles.
- 0x08 MAX_W, 16 bit (0xFFFF): maximum accepted width in cycles.
- 0x0C DELAY, 20 bit (0): flight delay in cycles.
- 0x10 PULSE, 16 bit (1): trigger length. 0 is treated as 1.
- 0x14 HOLD, 20 bit (0): dead time after the pulse.
- 0x18 N_DROP (RO): number of droplets evaluated.
- 0x1C N_SORT (RO): number of triggers fired.
- 0x20 N_MISS (RO): detections lost while busy.
- 0x24 STATUS (RO): [2:0] state code, [3] `asg_trig_o`.
- Unused bits read 0. Writes to RO or unmapped addresses are ignored.

FSM (state codes in brackets):
- IDLE (0): if EN and `det_i`=1, clear the width counter to 1 and go to MEAS.
- MEAS (1): while `det_i`=1, increment the width counter, saturating at 0xFFFF. On `det_i`=0:
  - increment N_DROP;
  - if MIN_W ≤ width ≤ MAX_W, load the delay counter with DELAY and go to WAIT;
  - otherwise go to IDLE.
- WAIT (2): if the delay counter is 0, load the pulse counter with max(PULSE,1) and go to FIRE, incrementing N_SORT. Otherwise decrement the delay counter.
- FIRE (3): `asg_trig_o`=1. Decrement the pulse counter. When it reaches 1, load HOLD and go to HOLD.
- HOLD (4): if the counter is 0, go to IDLE. Otherwise decrement it.

Rules:
- A rising edge of `det_i` (previous sample 0, current sample 1) seen in WAIT, FIRE or HOLD increments N_MISS. That droplet is not measured.
- EN=0 in any state sends the FSM to IDLE on the next edge and drops `asg_trig_o` the same edge. Counters are kept.
- Config registers are sampled only when a counter is loaded. A write mid-phase affects the next load.
- If MIN_W > MAX_W, every droplet is rejected; it is still counted in N_DROP.
- Counters wrap modulo 2^CW. If CLR and an increment occur on the same edge, the counter becomes 0.

## Timing
- All outputs are registered.
- Reset values: `asg_trig_o`=0, `busy_o`=0, `sys_ack`=0, `sys_err`=0, `sys_rdata`=0. The FSM resets to IDLE and all registers take their listed reset values.
- Width measurement: `det_i` is sampled high on W consecutive edges, so width = W.
- Trigger latency:
  - `det_i` is first sampled low at edge t0.
  - `asg_trig_o` rises at edge t0+DELAY+2.
  - It stays high for max(PULSE,1) cycles.
  - `busy_o` falls HOLD+1 cycles after `asg_trig_o` falls.
- Bus: `sys_ack` goes high exactly one cycle after any `sys_wen`|`sys_ren` strobe, for one cycle, on every address. `sys_rdata` is valid in the ack cycle. A write takes effect on the strobe edge.

## Test plan
- Accept: EN=1, MIN_W=4, MAX_W=10, DELAY=5, PULSE=3, HOLD=2, `det_i` high 6 cycles. Required: `asg_trig_o` high 3 cycles starting at t0+7; N_DROP=1, N_SORT=1; `busy_o` low 3 cycles after the trigger falls.
- Reject: same config, pulses of 3 and 11 cycles. Required: no trigger; N_DROP=2, N_SORT=0.
- Miss: DELAY=20, second `det_i` rise 5 cycles after the first falls. Required: one trigger; N_MISS=1, N_DROP=1.
- Abort: clear EN during FIRE. Required: `asg_trig_o` low on the next edge, STATUS=0, counters unchanged.
- Edge config: PULSE=0, DELAY=0. Required: 1-cycle trigger at t0+2.
- Reset and bus: assert `adc_rst_i` mid-FIRE. Required: `asg_trig_o`=0 immediately (asynchronous); a read of 0x08 returns 0xFFFF with ack 1 cycle after the strobe; CLR zeroes the counters.
